// File: rtl/bmult14x14_acc.sv
// Accumulator behind the fixed-latency 14x14 multiplier: tags each issued pair through a
// matching delay line, sums returned products per group, and queues finished groups in a 2-deep FIFO.
module bmult14x14_acc #(
    parameter int LAT   = 2,
    parameter int ACC_W = 36,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [13:0]      op_a,
    input  logic [13:0]      op_b,
    input  logic             op_last,
    output logic [13:0]      mul_a,
    output logic [13:0]      mul_b,
    input  logic [27:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_len,
    output logic             out_ovf
);

    logic             accept;
    logic             al_valid;
    logic             al_last;
    logic             push;
    logic             pop;

    logic             dl_valid [LAT];
    logic             dl_last  [LAT];

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] len;
    logic             ovf;
    logic             first;

    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] len_next;
    logic             ovf_next;

    logic [ACC_W-1:0] fifo_sum [2];
    logic [CNT_W-1:0] fifo_len [2];
    logic             fifo_ovf [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       lif;

    assign mul_a  = op_a;
    assign mul_b  = op_b;
    assign accept = op_valid & op_ready;

    // Credits cover both queued results and lasts still inside the multiplier, so a push never overflows.
    assign op_ready = ({1'b0, count} + {1'b0, lif}) < 3'd2;

    assign al_valid = dl_valid[LAT-1];
    assign al_last  = dl_last[LAT-1];
    assign push     = al_valid & al_last;
    assign pop      = out_valid & out_ready;

    assign out_valid = (count != 2'd0);
    assign out_sum   = fifo_sum[rd_ptr];
    assign out_len   = fifo_len[rd_ptr];
    assign out_ovf   = fifo_ovf[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                dl_valid[i] <= 1'b0;
                dl_last[i]  <= 1'b0;
            end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_last[i]  <= dl_last[i-1];
            end
            dl_valid[0] <= accept;
            dl_last[0]  <= accept & op_last;
        end
    end

    always_comb begin
        acc_base = first ? '0 : acc;
        sum_ext  = {1'b0, acc_base} + {{(ACC_W + 1 - 28){1'b0}}, mul_p};
        acc_next = sum_ext[ACC_W-1:0];
        len_next = (first ? '0 : len) + CNT_W'(1);
        ovf_next = (~first & ovf) | sum_ext[ACC_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            len   <= '0;
            ovf   <= 1'b0;
            first <= 1'b1;
        end else if (al_valid) begin
            acc   <= acc_next;
            len   <= len_next;
            ovf   <= ovf_next;
            first <= al_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lif <= 2'd0;
        end else begin
            case ({accept & op_last, push})
                2'b10:   lif <= lif + 2'd1;
                2'b01:   lif <= lif - 2'd1;
                default: lif <= lif;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_sum[i] <= '0;
                fifo_len[i] <= '0;
                fifo_ovf[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_sum[wr_ptr] <= acc_next;
                fifo_len[wr_ptr] <= len_next;
                fifo_ovf[wr_ptr] <= ovf_next;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
